// File: rtl/mips_pc_pkg.sv
// ---------------------------------------------------------------------------
// mips_pc_pkg
// Shared definitions for the program-counter stage and the branch
// resolution logic: PC width, reset vector, PC increment, redirect source
// encoding and the redirect FSM state type.
// ---------------------------------------------------------------------------
package mips_pc_pkg;

    localparam int          PC_W             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_BRANCH,
        SRC_JUMP
    } redirect_src_t;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } pc_state_t;

    // A jump outranks a taken branch issued in the same cycle.
    function automatic redirect_src_t select_src(input logic jump, input logic branch_taken);
        if (jump)
            return SRC_JUMP;
        else if (branch_taken)
            return SRC_BRANCH;
        else
            return SRC_NONE;
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// ---------------------------------------------------------------------------
// branch_target_adder
// Pure combinational target formation for branches and J-type jumps.
//   branch_pc4   : PC+4 of the branch/jump instruction
//   offset_sl2   : sign-extended offset, already shifted left by two
//   jump_target  : instr[25:0] of a J-type instruction
//   branch_tgt   : branch_pc4 + offset_sl2 (wraps modulo 2^DATA_W)
//   jump_tgt     : {branch_pc4[31:28], jump_target, 2'b00}
// ---------------------------------------------------------------------------
module branch_target_adder
    import mips_pc_pkg::*;
#(
    parameter int DATA_W = PC_W
) (
    input  logic [DATA_W-1:0] branch_pc4,
    input  logic [DATA_W-1:0] offset_sl2,
    input  logic [25:0]       jump_target,
    output logic [DATA_W-1:0] branch_tgt,
    output logic [DATA_W-1:0] jump_tgt
);

    assign branch_tgt = branch_pc4 + offset_sl2;

    // The jump stays inside the 256 MB region of the delay-slot PC.
    assign jump_tgt = {branch_pc4[DATA_W-1:DATA_W-4], jump_target, 2'b00};

endmodule

// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
// Architectural PC register with next-PC selection. A redirect (taken branch
// or jump) raised while the pipeline is stalled is parked in a one-entry
// slot and applied on the first unstalled cycle; while parked, younger
// redirects are dropped because the older one squashes them.
//
// Optional build macro: REDIRECT_CNT_EN adds redirect_cnt_o, a saturating
// count of cycles in which redirect_o was high.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   stall_i            hold the PC
//   branch_taken_i     taken branch this cycle
//   jump_i             J-type jump this cycle (wins over branch)
//   branch_pc4_i       PC+4 of the branch/jump
//   offset_sl2_i       shifted branch offset
//   jump_target_i      instr[25:0] of the jump
//   pc_o               current PC (registered)
//   pc_plus4_o         pc_o + 4
//   redirect_o         pc_o was just loaded with a redirect target
//   pending_o          redirect parked, waiting for the stall to clear
//   redirect_cnt_o     (REDIRECT_CNT_EN only) saturating redirect count
//
// state   | meaning
// ST_IDLE | no parked redirect; PC advances or takes a fresh redirect
// ST_PEND | redirect parked in buf_tgt until stall_i drops
// ---------------------------------------------------------------------------
module pc_redirect_unit
    import mips_pc_pkg::*;
#(
    parameter int                DATA_W   = PC_W,
    parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT[DATA_W-1:0]
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    input  logic [DATA_W-1:0] branch_pc4_i,
    input  logic [DATA_W-1:0] offset_sl2_i,
    input  logic [25:0]       jump_target_i,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] pc_plus4_o,
    output logic              redirect_o,
    output logic              pending_o
`ifdef REDIRECT_CNT_EN
    ,
    output logic [15:0]       redirect_cnt_o
`endif
);

    logic [DATA_W-1:0] branch_tgt;
    logic [DATA_W-1:0] jump_tgt;
    logic [DATA_W-1:0] sel_tgt;
    logic              req;
    redirect_src_t     src;

    pc_state_t         state;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] buf_tgt;
    logic              redirect_q;

    branch_target_adder #(
        .DATA_W (DATA_W)
    ) u_tgt (
        .branch_pc4  (branch_pc4_i),
        .offset_sl2  (offset_sl2_i),
        .jump_target (jump_target_i),
        .branch_tgt  (branch_tgt),
        .jump_tgt    (jump_tgt)
    );

    always_comb begin
        src     = select_src(jump_i, branch_taken_i);
        req     = (src != SRC_NONE);
        sel_tgt = branch_tgt;
        if (src == SRC_JUMP)
            sel_tgt = jump_tgt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            pc_q       <= RESET_PC;
            buf_tgt    <= '0;
            redirect_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!stall_i) begin
                        redirect_q <= req;
                        if (req)
                            pc_q <= sel_tgt;
                        else
                            pc_q <= pc_q + PC_INC[DATA_W-1:0];
                    end else begin
                        redirect_q <= 1'b0;
                        if (req) begin
                            buf_tgt <= sel_tgt;
                            state   <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    // Any request arriving here is younger than the parked
                    // one and is discarded, stalled or not.
                    if (!stall_i) begin
                        pc_q       <= buf_tgt;
                        redirect_q <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        redirect_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    redirect_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + PC_INC[DATA_W-1:0];
    assign redirect_o = redirect_q;
    assign pending_o  = (state == ST_PEND);

`ifdef REDIRECT_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (redirect_q && (cnt_q != 16'hFFFF))
            cnt_q <= cnt_q + 16'd1;
    end

    assign redirect_cnt_o = cnt_q;
`endif

endmodule
